// File: rtl/segre_mem_stage.sv
// segre_mem_stage: data-cache memory-access stage.
// Data array, dirty bits, MMU fills, store-buffer flushes, loads.
module segre_mem_stage #(
    parameter int WORD_SIZE         = 32,
    parameter int DCACHE_LANE_SIZE  = 128,
    parameter int DCACHE_NUM_LINES  = 4,
    parameter int DCACHE_INDEX_SIZE = $clog2(DCACHE_NUM_LINES),
    parameter int REG_SIZE          = 5,
    parameter int HF_PTR            = 4
) (
    input  logic                         clk_i,
    input  logic                         rsn_i,
    input  logic [WORD_SIZE-1:0]         addr_i,
    input  logic                         rf_we_i,
    input  logic [REG_SIZE-1:0]          rf_waddr_i,
    input  logic [DCACHE_INDEX_SIZE-1:0] addr_index_i,
    input  logic                         memop_rd_i,
    input  logic                         memop_wr_i,
    input  logic                         memop_sign_ext_i,
    input  logic [1:0]                   memop_type_i,
    input  logic [1:0]                   memop_type_flush_i,
    input  logic                         sb_hit_i,
    input  logic                         sb_flush_i,
    input  logic [WORD_SIZE-1:0]         sb_data_load_i,
    input  logic [WORD_SIZE-1:0]         sb_data_flush_i,
    input  logic [WORD_SIZE-1:0]         sb_addr_i,
    input  logic [HF_PTR-1:0]            instr_id_i,
    input  logic                         mmu_data_rdy_i,
    input  logic [DCACHE_LANE_SIZE-1:0]  mmu_data_i,
    input  logic [DCACHE_INDEX_SIZE-1:0] mmu_lru_index_i,
    output logic                         rf_we_o,
    output logic [REG_SIZE-1:0]          rf_waddr_o,
    output logic [WORD_SIZE-1:0]         rf_data_o,
    output logic [HF_PTR-1:0]            instr_id_o,
    output logic                         mmu_wb_o,
    output logic [DCACHE_INDEX_SIZE-1:0] mmu_wb_index_o,
    output logic [DCACHE_LANE_SIZE-1:0]  mmu_wb_data_o
);

    localparam int NUM_BYTES = DCACHE_LANE_SIZE / 8;
    localparam int OFF_W     = $clog2(NUM_BYTES);

    typedef logic [DCACHE_LANE_SIZE-1:0] line_t;

    line_t                       data_q [DCACHE_NUM_LINES];
    line_t                       data_d [DCACHE_NUM_LINES];
    logic [DCACHE_NUM_LINES-1:0] dirty_q;
    logic [DCACHE_NUM_LINES-1:0] dirty_d;

    function automatic logic [OFF_W-1:0] align_off(
        input logic [OFF_W-1:0] off,
        input logic [1:0]       size
    );
        logic [OFF_W-1:0] r;
        r = off;
        unique case (size)
            2'd0:    r = off;
            2'd1:    r[0] = 1'b0;
            default: r[1:0] = 2'b00;
        endcase
        return r;
    endfunction

    function automatic logic [NUM_BYTES-1:0] size_mask(
        input logic [1:0] size
    );
        logic [NUM_BYTES-1:0] m;
        unique case (size)
            2'd0:    m = NUM_BYTES'(1);
            2'd1:    m = NUM_BYTES'(3);
            default: m = NUM_BYTES'(15);
        endcase
        return m;
    endfunction

    logic                 fill;
    logic                 flush;
    logic                 victim;
    logic [OFF_W-1:0]     wr_off;
    logic [NUM_BYTES-1:0] wr_be;
    line_t                wr_data;
    line_t                wr_bits;

    assign fill    = mmu_data_rdy_i;
    assign flush   = memop_wr_i & sb_flush_i;
    assign victim  = fill & dirty_q[mmu_lru_index_i];
    assign wr_off  = align_off(sb_addr_i[OFF_W-1:0], memop_type_flush_i);
    assign wr_be   = size_mask(memop_type_flush_i) << wr_off;
    assign wr_data = line_t'(sb_data_flush_i) << {wr_off, 3'b000};

    // Expand the byte enables of the flush write into a bit mask
    always_comb begin
        wr_bits = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            wr_bits[b*8 +: 8] = {8{wr_be[b]}};
        end
    end

    // Next array state: fill first, then flush bytes merged on top
    always_comb begin
        for (int i = 0; i < DCACHE_NUM_LINES; i++) begin
            data_d[i] = data_q[i];
        end
        dirty_d = dirty_q;
        if (fill) begin
            data_d[mmu_lru_index_i]  = mmu_data_i;
            dirty_d[mmu_lru_index_i] = 1'b0;
        end
        if (flush) begin
            data_d[addr_index_i] = (data_d[addr_index_i] & ~wr_bits)
                                 | (wr_data & wr_bits);
            dirty_d[addr_index_i] = 1'b1;
        end
    end

    logic [OFF_W-1:0]     rd_off;
    line_t                rd_line;
    logic [WORD_SIZE-1:0] ld_data;
    logic                 sx;

    assign rd_off  = align_off(addr_i[OFF_W-1:0], memop_type_i);
    assign rd_line = data_q[addr_index_i] >> {rd_off, 3'b000};
    assign sx      = memop_sign_ext_i;

    // Load extraction from the pre-write line, or store-buffer bypass
    always_comb begin
        ld_data = rd_line[WORD_SIZE-1:0];
        unique case (memop_type_i)
            2'd0: ld_data = {{(WORD_SIZE-8){sx & rd_line[7]}},
                             rd_line[7:0]};
            2'd1: ld_data = {{(WORD_SIZE-16){sx & rd_line[15]}},
                             rd_line[15:0]};
            default: ld_data = rd_line[WORD_SIZE-1:0];
        endcase
        if (sb_hit_i) begin
            ld_data = sb_data_load_i;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{sb_addr_i[WORD_SIZE-1:OFF_W],
                           rd_line[DCACHE_LANE_SIZE-1:WORD_SIZE]};

    // Data array and dirty bits
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            for (int i = 0; i < DCACHE_NUM_LINES; i++) begin
                data_q[i] <= '0;
            end
            dirty_q <= '0;
        end else begin
            for (int i = 0; i < DCACHE_NUM_LINES; i++) begin
                data_q[i] <= data_d[i];
            end
            dirty_q <= dirty_d;
        end
    end

    // Writeback-side pipeline latch
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_data_o  <= '0;
            instr_id_o <= '0;
        end else begin
            rf_we_o    <= rf_we_i;
            rf_waddr_o <= rf_waddr_i;
            rf_data_o  <= memop_rd_i ? ld_data : addr_i;
            instr_id_o <= instr_id_i;
        end
    end

    // Dirty-victim report to the MMU, one pulse per evicted dirty line
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            mmu_wb_o       <= 1'b0;
            mmu_wb_index_o <= '0;
            mmu_wb_data_o  <= '0;
        end else begin
            mmu_wb_o <= victim;
            if (victim) begin
                mmu_wb_index_o <= mmu_lru_index_i;
                mmu_wb_data_o  <= data_q[mmu_lru_index_i];
            end
        end
    end

endmodule

// File: tb/tb_segre_mem_stage.sv
// tb_segre_mem_stage: directed scoreboard bench.
// Driver queues expected outputs; monitor compares each cycle.
module tb_segre_mem_stage;

    localparam logic [1:0] B = 2'd0;
    localparam logic [1:0] H = 2'd1;
    localparam logic [1:0] W = 2'd2;

    logic         clk;
    logic         rsn_i;
    logic [31:0]  addr_i;
    logic         rf_we_i;
    logic [4:0]   rf_waddr_i;
    logic [1:0]   addr_index_i;
    logic         memop_rd_i;
    logic         memop_wr_i;
    logic         memop_sign_ext_i;
    logic [1:0]   memop_type_i;
    logic [1:0]   memop_type_flush_i;
    logic         sb_hit_i;
    logic         sb_flush_i;
    logic [31:0]  sb_data_load_i;
    logic [31:0]  sb_data_flush_i;
    logic [31:0]  sb_addr_i;
    logic [3:0]   instr_id_i;
    logic         mmu_data_rdy_i;
    logic [127:0] mmu_data_i;
    logic [1:0]   mmu_lru_index_i;
    logic         rf_we_o;
    logic [4:0]   rf_waddr_o;
    logic [31:0]  rf_data_o;
    logic [3:0]   instr_id_o;
    logic         mmu_wb_o;
    logic [1:0]   mmu_wb_index_o;
    logic [127:0] mmu_wb_data_o;

    segre_mem_stage dut (
        .clk_i              (clk),
        .rsn_i              (rsn_i),
        .addr_i             (addr_i),
        .rf_we_i            (rf_we_i),
        .rf_waddr_i         (rf_waddr_i),
        .addr_index_i       (addr_index_i),
        .memop_rd_i         (memop_rd_i),
        .memop_wr_i         (memop_wr_i),
        .memop_sign_ext_i   (memop_sign_ext_i),
        .memop_type_i       (memop_type_i),
        .memop_type_flush_i (memop_type_flush_i),
        .sb_hit_i           (sb_hit_i),
        .sb_flush_i         (sb_flush_i),
        .sb_data_load_i     (sb_data_load_i),
        .sb_data_flush_i    (sb_data_flush_i),
        .sb_addr_i          (sb_addr_i),
        .instr_id_i         (instr_id_i),
        .mmu_data_rdy_i     (mmu_data_rdy_i),
        .mmu_data_i         (mmu_data_i),
        .mmu_lru_index_i    (mmu_lru_index_i),
        .rf_we_o            (rf_we_o),
        .rf_waddr_o         (rf_waddr_o),
        .rf_data_o          (rf_data_o),
        .instr_id_o         (instr_id_o),
        .mmu_wb_o           (mmu_wb_o),
        .mmu_wb_index_o     (mmu_wb_index_o),
        .mmu_wb_data_o      (mmu_wb_data_o)
    );

    typedef struct {
        logic         we;
        logic [4:0]   wa;
        logic [31:0]  d;
        logic [3:0]   id;
        logic         wb;
        logic [1:0]   wi;
        logic [127:0] wd;
        logic         cw;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [3:0] tid = 4'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] a,
                       input logic [127:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // Monitor: compare registered outputs against the queued expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("rf_we", 128'(rf_we_o), 128'(e.we));
            chk("rf_waddr", 128'(rf_waddr_o), 128'(e.wa));
            chk("rf_data", 128'(rf_data_o), 128'(e.d));
            chk("instr_id", 128'(instr_id_o), 128'(e.id));
            chk("mmu_wb", 128'(mmu_wb_o), 128'(e.wb));
            if (e.cw) begin
                chk("wb_index", 128'(mmu_wb_index_o), 128'(e.wi));
                chk("wb_data", mmu_wb_data_o, e.wd);
            end
        end
    end

    task automatic clr();
        rsn_i = 1'b0;
        addr_i = '0;
        rf_we_i = 1'b0;
        rf_waddr_i = '0;
        addr_index_i = '0;
        memop_rd_i = 1'b0;
        memop_wr_i = 1'b0;
        memop_sign_ext_i = 1'b0;
        memop_type_i = '0;
        memop_type_flush_i = '0;
        sb_hit_i = 1'b0;
        sb_flush_i = 1'b0;
        sb_data_load_i = '0;
        sb_data_flush_i = '0;
        sb_addr_i = '0;
        instr_id_i = '0;
        mmu_data_rdy_i = 1'b0;
        mmu_data_i = '0;
        mmu_lru_index_i = '0;
    endtask

    task automatic go(input logic [31:0] ed, input logic ewb,
                      input logic [1:0] ewi, input logic [127:0] ewd,
                      input logic cw);
        exp_t e;
        e.we = rsn_i ? 1'b0 : rf_we_i;
        e.wa = rsn_i ? 5'd0 : rf_waddr_i;
        e.id = rsn_i ? 4'd0 : instr_id_i;
        e.d  = rsn_i ? 32'd0 : ed;
        e.wb = rsn_i ? 1'b0 : ewb;
        e.wi = rsn_i ? 2'd0 : ewi;
        e.wd = rsn_i ? 128'd0 : ewd;
        e.cw = cw | rsn_i;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
        clr();
    endtask

    task automatic nop(input logic [31:0] ed);
        go(ed, 1'b0, 2'd0, 128'd0, 1'b0);
    endtask

    task automatic wb(input logic [1:0] ix, input logic [127:0] ln);
        go(32'd0, 1'b1, ix, ln, 1'b1);
    endtask

    task automatic ld(input logic [31:0] a, input logic [1:0] ix,
                      input logic [1:0] t, input logic s);
        rf_we_i = 1'b1;
        rf_waddr_i = {1'b1, tid};
        instr_id_i = tid;
        tid = tid + 4'd1;
        memop_rd_i = 1'b1;
        addr_i = a;
        addr_index_i = ix;
        memop_type_i = t;
        memop_sign_ext_i = s;
    endtask

    task automatic fl(input logic [31:0] a, input logic [1:0] ix,
                      input logic [1:0] t, input logic [31:0] d);
        memop_wr_i = 1'b1;
        sb_flush_i = 1'b1;
        sb_addr_i = a;
        addr_index_i = ix;
        memop_type_flush_i = t;
        sb_data_flush_i = d;
    endtask

    task automatic fi(input logic [1:0] ix, input logic [127:0] ln);
        mmu_data_rdy_i = 1'b1;
        mmu_lru_index_i = ix;
        mmu_data_i = ln;
    endtask

    initial begin : drv
        clr();
        @(negedge clk);
        #1;
        rsn_i = 1'b1; go(0, 0, 0, 0, 1);
        rsn_i = 1'b1; go(0, 0, 0, 0, 1);
        // word load from a freshly filled line
        fi(1, 128'h0F0E0D0C_0B0A0908_07060504_03020100); nop(0);
        ld(32'h14, 1, W, 0); nop(32'h07060504);
        // byte/half extension and alignment
        fi(0, 128'h00000000_00000000_80000000_91230000); nop(0);
        ld(32'h7, 0, B, 1); nop(32'hFFFFFF80);
        ld(32'h7, 0, B, 0); nop(32'h00000080);
        ld(32'h3, 0, H, 1); nop(32'hFFFF9123);
        ld(32'h3, 0, H, 0); nop(32'h00009123);
        // fill and load on the same index: load sees old line
        fi(0, {4{32'h11111111}}); ld(32'h4, 0, W, 0); nop(32'h80000000);
        ld(32'h0, 0, W, 0); nop(32'h11111111);
        // half flush at offset 7 (aligned to 6) with a same-cycle load
        fi(2, 128'h33333333_22222222_11111111_00000000); nop(0);
        fl(32'h107, 2, H, 32'hCAFEBEEF); ld(32'h4, 2, W, 0);
        nop(32'h11111111);
        ld(32'h4, 2, W, 0); nop(32'hBEEF1111);
        ld(32'h8, 2, W, 0); nop(32'h22222222);
        // dirty victim on idx 3, then a clean refill
        fl(32'hE, 3, W, 32'hA1B2C3D4); nop(0);
        fi(3, {4{32'h55555555}});
        wb(3, 128'hA1B2C3D4_00000000_00000000_00000000);
        nop(0);
        fi(3, {4{32'h55555555}}); nop(0);
        nop(0);
        // back-to-back dirty victims
        fl(32'h0, 3, B, 32'h12345677); nop(0);
        fi(2, 128'd0); wb(2, 128'h33333333_22222222_BEEF1111_00000000);
        fi(3, 128'd0); wb(3, 128'h55555555_55555555_55555555_55555577);
        nop(0);
        // fill and flush to the same index merge, store wins
        fi(1, {4{32'hAAAAAAAA}}); fl(32'h8, 1, W, 32'h01020304); nop(0);
        ld(32'h8, 1, W, 0); nop(32'h01020304);
        ld(32'h0, 1, W, 0); nop(32'hAAAAAAAA);
        fi(1, 128'd0); wb(1, 128'hAAAAAAAA_01020304_AAAAAAAA_AAAAAAAA);
        // store-buffer bypass and address pass-through
        ld(32'h4, 1, W, 0); sb_hit_i = 1'b1;
        sb_data_load_i = 32'h12345678; nop(32'h12345678);
        rf_we_i = 1'b1; rf_waddr_i = 5'd9; instr_id_i = 4'hA;
        addr_i = 32'hDEADBEEF; nop(32'hDEADBEEF);
        // reset alongside a dirty fill
        fl(32'h0, 0, W, 32'hFFFFFFFF); nop(0);
        rsn_i = 1'b1; fi(0, {4{32'h99999999}}); rf_we_i = 1'b1;
        addr_i = 32'hDEADBEEF; go(0, 0, 0, 0, 1);
        ld(32'h0, 0, W, 0); nop(0);
        ld(32'h4, 1, W, 0); nop(0);
        fi(0, {4{32'h99999999}}); go(0, 0, 0, 0, 1);
        go(0, 0, 0, 0, 1);
        for (int i = 0; i < 5 && q.size() != 0; i++) begin
            @(negedge clk);
        end
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/segre_mem_stage.md
# segre_mem_stage

Memory-access stage directly downstream of the tag-lookup (TL) stage. It holds the data-cache data array and dirty bits, and installs MMU line fills. It applies store-buffer flush writes to the array, and performs load extraction with sign/zero extension. Results go to a one-cycle pipeline latch that feeds writeback, and dirty victims are reported to the MMU.

## Interface
Parameters:
- WORD_SIZE, 32, data/address width
- DCACHE_LANE_SIZE, 128, line width in bits (16 bytes)
- DCACHE_NUM_LINES, 4, number of lines; DCACHE_INDEX_SIZE = clog2 = 2
- REG_SIZE, 5, register address width
- HF_PTR, 4, instruction-id width

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rsn_i  in  1  reset, synchronous, active-high (rsn_i=1 resets)
- addr_i  in  WORD_SIZE  ALU result / memory address from TL
- rf_we_i  in  1  register write enable
- rf_waddr_i  in  REG_SIZE  destination register
- addr_index_i  in  DCACHE_INDEX_SIZE  line index resolved by TL
- memop_rd_i  in  1  load
- memop_wr_i  in  1  store-buffer flush write
- memop_sign_ext_i  in  1  sign-extend load
- memop_type_i  in  2  load size: BYTE=0, HALF=1, WORD=2
- memop_type_flush_i  in  2  flush write size, same encoding
- sb_hit_i  in  1  load served by store buffer
- sb_flush_i  in  1  flush data valid
- sb_data_load_i  in  WORD_SIZE  store-buffer load data, already extended
- sb_data_flush_i  in  WORD_SIZE  flush data, right-aligned
- sb_addr_i  in  WORD_SIZE  flush address
- instr_id_i  in  HF_PTR  instruction id
- mmu_data_rdy_i  in  1  fill valid
- mmu_data_i  in  DCACHE_LANE_SIZE  fill line
- mmu_lru_index_i  in  DCACHE_INDEX_SIZE  fill index
- rf_we_o  out  1  registered
- rf_waddr_o  out  REG_SIZE  registered
- rf_data_o  out  WORD_SIZE  load result, or addr_i pass-through
- instr_id_o  out  HF_PTR  registered
- mmu_wb_o  out  1  dirty-victim writeback pulse
- mmu_wb_index_o  out  DCACHE_INDEX_SIZE  victim index
- mmu_wb_data_o  out  DCACHE_LANE_SIZE  victim line

## Operation
- Storage: data[NUM_LINES] of LANE_SIZE bits, dirty[NUM_LINES].
- Fill: when mmu_data_rdy_i=1, data[mmu_lru_index_i] <= mmu_data_i and its dirty bit is cleared. If the old dirty bit was 1, the next cycle drives mmu_wb_o=1 with the pre-fill line and index.
- Flush write: when memop_wr_i & sb_flush_i, the access is line addr_index_i at byte offset sb_addr_i[3:0].
  - BYTE writes 1 byte.
  - HALF writes 2 bytes; offset bit 0 is forced to 0.
  - WORD writes 4 bytes; offset bits [1:0] are forced to 0.
  - Data comes from the low bytes of sb_data_flush_i, little-endian. dirty is set to 1.
  - Other bytes of the line are unchanged.
- Load: when memop_rd_i, the result is sb_data_load_i if sb_hit_i. Otherwise, extract from data[addr_index_i] at offset addr_i[3:0], using the same alignment forcing as flush writes.
  - BYTE/HALF results are sign-extended if memop_sign_ext_i=1, else zero-extended.
- Non-load: rf_data_o <= addr_i.
- Simultaneous events:
  - Fill and flush write to the same index: the filled line is merged with the store bytes, store bytes win, and dirty=1. No writeback is issued for that fill's victim unless the old dirty bit was 1.
  - Flush and load in the same cycle: the load reads the pre-write array (read-before-write).
  - Fill and load to the same index: the load reads the pre-fill line.
- memop_type=3 is illegal and treated as WORD.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N. No stall input; a TL bubble arrives as rf_we_i=0, memop_rd_i=0, memop_wr_i=0.
- Array writes take effect at the edge; a load in the following cycle sees the new data.
- mmu_wb_o is high exactly one cycle per dirty-victim fill. Back-to-back fills produce back-to-back pulses, each carrying its own victim.
- Reset (rsn_i=1 at an edge):
  - data and dirty are cleared to 0.
  - rf_we_o=0, rf_waddr_o=0, rf_data_o=0, instr_id_o=0.
  - mmu_wb_o=0, mmu_wb_index_o=0, mmu_wb_data_o=0.
  - A fill or write in the reset cycle is discarded.
  - A writeback pending from the previous cycle is dropped.

## Test plan
- Fill idx 1 with 0x0F0E0D0C_0B0A0908_07060504_03020100, then load WORD at addr 0x...14, idx 1 -> rf_data_o=0x07060504 one cycle later.
- Load BYTE offset 0x7 of a line holding 0x80 there: sign_ext=1 -> 0xFFFFFF80; sign_ext=0 -> 0x00000080. HALF offset 0x3 is aligned to offset 2.
- Flush HALF 0xBEEF at offset 6 into idx 2, then load WORD offset 4 -> upper half 0xBEEF, lower half unchanged. dirty[2]=1.
- Flush to idx 3, then fill idx 3 with new line -> next cycle mmu_wb_o=1, index=3, data=old line with store; the following cycle mmu_wb_o=0. A second fill to idx 3 gives no pulse.
- Load with sb_hit_i=1, sb_data_load_i=0x12345678 -> 0x12345678 regardless of array. Non-memop with rf_we_i=1, addr_i=0xDEADBEEF -> rf_data_o=0xDEADBEEF.
- Assert rsn_i mid-sequence alongside a fill -> all outputs 0 next cycle, subsequent loads read 0, and no mmu_wb_o pulse.
